mux_4x1_rr_arbiter: RTL and testbench

- Round-robin controller that shares one 4-input, WIDTH-bit multiplexer between four requesters a, b, c and d.
- Each requester raises a request bit. The block grants one requester at a time and drives the mux select from a register.
- It presents the selected data with a valid flag.
- It sits in front of the shared mux datapath and replaces the free-running select stimulus used today.

---
 rtl/mux_arb_pkg.sv | 39 +++
 rtl/mux_4x1_dp.sv | 25 ++
 rtl/mux_4x1_rr_arbiter.sv | 134 +++++++++++++
 tb/tb_mux_4x1_rr_arbiter.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/mux_arb_pkg.sv
// Shared types and helpers for the 4-requester round-robin mux arbiter:
// state encoding, arbitration result struct, rotating priority scan.
package mux_arb_pkg;

    localparam int N_REQ = 4;
    localparam int SEL_W = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    typedef struct packed {
        logic             found;
        logic [SEL_W-1:0] idx;
    } rr_pick_t;

    // First set request scanning from last_ptr+1 upward, wrapping 3->0.
    // The loop runs furthest-first so the nearest candidate is written last.
    function automatic rr_pick_t rr_pick(input logic [N_REQ-1:0] req,
                                         input logic [SEL_W-1:0] last_ptr);
        rr_pick_t         res;
        logic [SEL_W-1:0] cand;
        res = '0;
        for (int i = N_REQ; i >= 1; i--) begin
            cand = last_ptr + SEL_W'(i);
            if (req[cand]) begin
                res.found = 1'b1;
                res.idx   = cand;
            end
        end
        return res;
    endfunction

    function automatic logic [N_REQ-1:0] to_onehot(input logic [SEL_W-1:0] idx);
        return N_REQ'(1) << idx;
    endfunction

endpackage

// File: rtl/mux_4x1_dp.sv
// Shared 4:1 WIDTH-bit multiplexer; purely combinational, select comes
// from the arbiter's select register.
module mux_4x1_dp #(
    parameter int WIDTH = 1
) (
    input  logic [1:0]       i_sel,
    input  logic [WIDTH-1:0] i_d0,
    input  logic [WIDTH-1:0] i_d1,
    input  logic [WIDTH-1:0] i_d2,
    input  logic [WIDTH-1:0] i_d3,
    output logic [WIDTH-1:0] o_y
);

    always_comb begin
        o_y = i_d0;
        case (i_sel)
            2'd0: o_y = i_d0;
            2'd1: o_y = i_d1;
            2'd2: o_y = i_d2;
            2'd3: o_y = i_d3;
            default: o_y = i_d0;
        endcase
    end

endmodule

// File: rtl/mux_4x1_rr_arbiter.sv
// Round-robin arbiter sharing one 4:1 mux between requesters a..d, with a
// per-grant hold limit. Define MUX_ARB_LOCK_EN to add the lock input.
module mux_4x1_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int WIDTH    = 1,
    parameter int MAX_HOLD = 4   // must be >= 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       req,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
`ifdef MUX_ARB_LOCK_EN
    input  logic             lock,
`endif
    output logic [3:0]       grant,
    output logic [1:0]       select,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    output arb_state_t       dbg_state
);

    localparam int                CNT_W    = $clog2(MAX_HOLD + 1);
    localparam logic [CNT_W-1:0]  HOLD_MAX = CNT_W'(MAX_HOLD);
    localparam logic [CNT_W-1:0]  HOLD_ONE = CNT_W'(1);

    // Output contract: out_valid marks the cycles in which out carries the
    // granted requester's data; grant[select] equals out_valid and out is
    // zero whenever out_valid is low. There is no ready/backpressure.
    arb_state_t       r_state;
    logic [CNT_W-1:0] r_hold_cnt;
    logic [SEL_W-1:0] r_last_ptr;
    logic [N_REQ-1:0] r_grant;
    logic [SEL_W-1:0] r_select;
    logic             r_valid;

    logic             w_lock;
    rr_pick_t         w_pick_idle;
    rr_pick_t         w_pick_next;
    logic [WIDTH-1:0] w_mux;

`ifdef MUX_ARB_LOCK_EN
    assign w_lock = lock;
`else
    assign w_lock = 1'b0;
`endif

    assign w_pick_idle = rr_pick(req, r_last_ptr);
    // Excluding the current owner makes one scan serve both release and preempt.
    assign w_pick_next = rr_pick(req & ~to_onehot(r_select), r_select);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_hold_cnt <= '0;
            r_last_ptr <= 2'd3;
            r_grant    <= '0;
            r_select   <= '0;
            r_valid    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_pick_idle.found) begin
                        r_state    <= GRANT;
                        r_grant    <= to_onehot(w_pick_idle.idx);
                        r_select   <= w_pick_idle.idx;
                        r_valid    <= 1'b1;
                        r_hold_cnt <= HOLD_ONE;
                    end else begin
                        r_grant    <= '0;
                        r_select   <= '0;
                        r_valid    <= 1'b0;
                        r_hold_cnt <= '0;
                    end
                end
                GRANT: begin
                    if (!req[r_select]) begin
                        r_last_ptr <= r_select;
                        if (w_pick_next.found) begin
                            r_grant    <= to_onehot(w_pick_next.idx);
                            r_select   <= w_pick_next.idx;
                            r_hold_cnt <= HOLD_ONE;
                        end else begin
                            r_state    <= IDLE;
                            r_grant    <= '0;
                            r_select   <= '0;
                            r_valid    <= 1'b0;
                            r_hold_cnt <= '0;
                        end
                    end else if (r_hold_cnt == HOLD_MAX) begin
                        if (w_lock) begin
                            r_hold_cnt <= HOLD_MAX;
                        end else if (w_pick_next.found) begin
                            r_last_ptr <= r_select;
                            r_grant    <= to_onehot(w_pick_next.idx);
                            r_select   <= w_pick_next.idx;
                            r_hold_cnt <= HOLD_ONE;
                        end else begin
                            r_hold_cnt <= HOLD_ONE;
                        end
                    end else begin
                        r_hold_cnt <= r_hold_cnt + HOLD_ONE;
                    end
                end
                default: begin
                    r_state    <= IDLE;
                    r_grant    <= '0;
                    r_select   <= '0;
                    r_valid    <= 1'b0;
                    r_hold_cnt <= '0;
                end
            endcase
        end
    end

    mux_4x1_dp #(.WIDTH(WIDTH)) u_dp (
        .i_sel (r_select),
        .i_d0  (a),
        .i_d1  (b),
        .i_d2  (c),
        .i_d3  (d),
        .o_y   (w_mux)
    );

    assign grant     = r_grant;
    assign select    = r_select;
    assign out_valid = r_valid;
    assign out       = r_valid ? w_mux : '0;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_mux_4x1_rr_arbiter.sv
// Bench for mux_4x1_rr_arbiter: directed per-cycle vectors feed an expected
// queue, a monitor pops and compares the outputs after every rising edge.
module tb_mux_4x1_rr_arbiter;
  import mux_arb_pkg::*;

  localparam int WIDTH = 1;
  localparam int MAX_HOLD = 4;
  localparam int EXP_W = 4 + 2 + 1 + WIDTH + 1;

  logic clk;
  logic rst;
  logic [3:0] req;
  logic [WIDTH-1:0] a, b, c, d;
  logic lock_s;
  logic [3:0] grant;
  logic [1:0] select;
  logic [WIDTH-1:0] out;
  logic out_valid;
  arb_state_t dbg_state;

  logic [EXP_W-1:0] exp_q[$];
  string name_q[$];
  int n_checks;
  int n_pass;

  mux_4x1_rr_arbiter #(.WIDTH(WIDTH), .MAX_HOLD(MAX_HOLD)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .a         (a),
    .b         (b),
    .c         (c),
    .d         (d),
`ifdef MUX_ARB_LOCK_EN
    .lock      (lock_s),
`endif
    .grant     (grant),
    .select    (select),
    .out       (out),
    .out_valid (out_valid),
    .dbg_state (dbg_state)
  );

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // scoreboard monitor
  logic [EXP_W-1:0] mon_exp;
  logic [EXP_W-1:0] mon_act;
  string mon_name;
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_exp = exp_q.pop_front();
      mon_name = name_q.pop_front();
      mon_act = {grant, select, out_valid, out, logic'(dbg_state)};
      n_checks++;
      if (mon_act !== mon_exp)
        $display("FAIL %s: got grant=%b sel=%0d valid=%b out=%b st=%b, expected grant=%b sel=%0d valid=%b out=%b st=%b",
                 mon_name, mon_act[8:5], mon_act[4:3], mon_act[2], mon_act[1], mon_act[0],
                 mon_exp[8:5], mon_exp[4:3], mon_exp[2], mon_exp[1], mon_exp[0]);
      else
        n_pass++;
    end
  end

  // driver tasks
  task automatic set_data(input logic [WIDTH-1:0] da, input logic [WIDTH-1:0] db,
                          input logic [WIDTH-1:0] dc, input logic [WIDTH-1:0] dd);
    a = da; b = db; c = dc; d = dd;
  endtask

  // Drive one cycle of inputs and queue the outputs expected after the next edge.
  task automatic step(input logic r, input logic [3:0] rq, input logic lk,
                      input logic [3:0] eg, input logic [1:0] es, input logic ev,
                      input logic [WIDTH-1:0] eo, input string nm);
    rst = r;
    req = rq;
    lock_s = lk;
    exp_q.push_back({eg, es, ev, eo, ev});
    name_q.push_back(nm);
    @(negedge clk);
  endtask

  task automatic idle_step(input logic r, input logic [3:0] rq, input string nm);
    step(r, rq, 1'b0, 4'b0000, 2'd0, 1'b0, '0, nm);
  endtask

  initial begin
    int k;
    logic [1:0] idx;
    logic [WIDTH-1:0] dv;
    n_checks = 0;
    n_pass = 0;
    rst = 1'b1;
    req = 4'b1111;
    lock_s = 1'b0;
    set_data(1'b1, 1'b0, 1'b1, 1'b0);
    @(negedge clk);

    // reset with all requesting, then full contention 0,1,2,3,0
    idle_step(1'b1, 4'b1111, "reset_0");
    idle_step(1'b1, 4'b1111, "reset_1");
    for (int s = 0; s < 17; s++) begin
      idx = 2'((s / MAX_HOLD) % 4);
      dv = (idx == 2'd0 || idx == 2'd2) ? 1'b1 : 1'b0;
      step(1'b0, 4'b1111, 1'b0, 4'b0001 << idx, idx, 1'b1, dv, $sformatf("contend_%0d", s));
    end

    // single requester c: hold counter wraps, then preempted by b
    idle_step(1'b1, 4'b0000, "reset_single");
    set_data(1'b0, 1'b0, 1'b1, 1'b0);
    for (int s = 0; s < 6; s++)
      step(1'b0, 4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b1, $sformatf("single_%0d", s));
    step(1'b0, 4'b0110, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b1, "wrap_hold3");
    step(1'b0, 4'b0110, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b1, "wrap_hold4");
    step(1'b0, 4'b0110, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0, "wrap_preempt");
    idle_step(1'b0, 4'b0000, "single_release");

    // release with handoff 1 -> 3
    idle_step(1'b1, 4'b0000, "reset_handoff");
    set_data(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 4'b0010, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b1, "handoff_g1");
    step(1'b0, 4'b1010, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b1, "handoff_hold");
    step(1'b0, 4'b1000, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b0, "handoff_g3");
    idle_step(1'b0, 4'b0000, "handoff_idle");

    // release to idle, then priority resumes after requester 0
    idle_step(1'b1, 4'b0000, "reset_idle");
    set_data(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 4'b0001, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b1, "idle_g0");
    step(1'b0, 4'b0001, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b1, "idle_g0_hold");
    idle_step(1'b0, 4'b0000, "idle_drop");
    step(1'b0, 4'b0011, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0, "idle_rr_next");

    // mid-grant reset
    idle_step(1'b1, 4'b0000, "reset_mid");
    set_data(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b1, "mid_g2");
    step(1'b0, 4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b1, "mid_g2_hold2");
    idle_step(1'b1, 4'b0100, "mid_reset");
    step(1'b0, 4'b1111, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0, "mid_after_g0");

`ifdef MUX_ARB_LOCK_EN
    idle_step(1'b1, 4'b0000, "reset_lock");
    set_data(1'b1, 1'b0, 1'b0, 1'b0);
    for (int s = 0; s < 8; s++)
      step(1'b0, 4'b0011, 1'b1, 4'b0001, 2'd0, 1'b1, 1'b1, $sformatf("lock_hold_%0d", s));
    step(1'b0, 4'b0011, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0, "lock_off_g1");
    step(1'b0, 4'b0001, 1'b1, 4'b0001, 2'd0, 1'b1, 1'b1, "lock_release");
`endif

    // drain the scoreboard within a bounded number of cycles
    k = 0;
    while (exp_q.size() > 0 && k < 8) begin
      @(negedge clk);
      k++;
    end
    if (exp_q.size() > 0) begin
      n_checks++;
      $display("FAIL drain_timeout: %0d expected entries left, required 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
